// File: rtl/cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_sweep_checker
//  Brief    : Sweeps every operand pair into a magnitude comparator, samples
//             its gt/eq/lt flags after a settle interval and scores them.
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_sweep_checker #(
   parameter int WIDTH         = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic               gt_in,
   input  logic               eq_in,
   input  logic               lt_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);

   localparam int               c_ew      = 2 * WIDTH + 1;
   localparam logic [3:0]       c_settle  = 4'(SETTLE_CYCLES);
   localparam logic [WIDTH-1:0] c_ones    = '1;
   localparam logic [WIDTH-1:0] c_op_one  = WIDTH'(1);
   localparam logic [c_ew-1:0]  c_err_one = c_ew'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            r_state, w_state;
   logic [WIDTH-1:0]  r_a, w_a, r_b, w_b;
   logic [WIDTH-1:0]  r_fail_a, w_fail_a, r_fail_b, w_fail_b;
   logic [c_ew-1:0]   r_err, w_err;
   logic [3:0]        r_cnt, w_cnt;
   logic              r_busy, w_busy, r_done, w_done, r_pass, w_pass;
   logic              r_fail_valid, w_fail_valid;
   logic [2:0]        w_expected;
   logic              w_mismatch;

   // Exactly one flag is expected; multi-hot and all-zero both mismatch.
   assign w_expected = (r_a > r_b)  ? 3'b100 :
                       (r_a == r_b) ? 3'b010 : 3'b001;
   assign w_mismatch = ({gt_in, eq_in, lt_in} != w_expected);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_valid <= 1'b0;
         r_fail_a     <= '0;
         r_fail_b     <= '0;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_state;
         r_a          <= w_a;
         r_b          <= w_b;
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_pass       <= w_pass;
         r_err        <= w_err;
         r_fail_valid <= w_fail_valid;
         r_fail_a     <= w_fail_a;
         r_fail_b     <= w_fail_b;
         r_cnt        <= w_cnt;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_a          = r_a;
      w_b          = r_b;
      w_busy       = r_busy;
      w_done       = r_done;
      w_pass       = r_pass;
      w_err        = r_err;
      w_fail_valid = r_fail_valid;
      w_fail_a     = r_fail_a;
      w_fail_b     = r_fail_b;
      w_cnt        = r_cnt;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state      = SETTLE;
               w_a          = '0;
               w_b          = '0;
               w_busy       = 1'b1;
               w_done       = 1'b0;
               w_pass       = 1'b0;
               w_err        = '0;
               w_fail_valid = 1'b0;
               w_fail_a     = '0;
               w_fail_b     = '0;
               w_cnt        = c_settle;
            end
         end
         SETTLE: begin
            w_cnt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state = CHECK;
            end
         end
         CHECK: begin
            if (w_mismatch) begin
               w_err = r_err + c_err_one;
               if (!r_fail_valid) begin
                  w_fail_valid = 1'b1;
                  w_fail_a     = r_a;
                  w_fail_b     = r_b;
               end
            end
            if (r_a == c_ones && r_b == c_ones) begin
               // Last pair: operands stay parked on all-ones.
               w_state = DONE;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_pass  = (w_err == '0);
            end else begin
               w_b = r_b + c_op_one;
               if (r_b == c_ones) begin
                  w_a = r_a + c_op_one;
               end
               w_cnt   = c_settle;
               w_state = SETTLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign a_out      = r_a;
   assign b_out      = r_b;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err;
   assign fail_valid = r_fail_valid;
   assign fail_a     = r_fail_a;
   assign fail_b     = r_fail_b;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_sweep_checker
//  Brief    : Drives two checker instances (settle 1 and 3) from a fault-
//             injecting comparator model and scores them against a sweep model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_sweep_checker;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_v [2];
   logic [2:0] fl      [2];
   logic [1:0] a_o     [2];
   logic [1:0] b_o     [2];
   logic       busy_o  [2];
   logic       done_o  [2];
   logic       pass_o  [2];
   logic [4:0] err_o   [2];
   logic       fv_o    [2];
   logic [1:0] fa_o    [2];
   logic [1:0] fb_o    [2];

   int          mode_v  [2];
   logic [15:0] mask_v  [2];
   logic [2:0]  noise_v [2];
   logic [2:0]  bx_v    [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cmp_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .a_out(a_o[0]), .b_out(b_o[0]),
      .gt_in(fl[0][2]), .eq_in(fl[0][1]), .lt_in(fl[0][0]),
      .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
      .err_count(err_o[0]), .fail_valid(fv_o[0]),
      .fail_a(fa_o[0]), .fail_b(fb_o[0])
   );

   cmp_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .a_out(a_o[1]), .b_out(b_o[1]),
      .gt_in(fl[1][2]), .eq_in(fl[1][1]), .lt_in(fl[1][0]),
      .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
      .err_count(err_o[1]), .fail_valid(fv_o[1]),
      .fail_a(fa_o[1]), .fail_b(fb_o[1])
   );

   function automatic int s_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [2:0] ideal_f(input int a, input int b);
      if (a > b)  return 3'b100;
      if (a == b) return 3'b010;
      return 3'b001;
   endfunction

   // Comparator under test: ideal, or one of several fault behaviours.
   function automatic logic [2:0] flags_f(input int m, input int a, input int b,
                                          input int ph, input int s,
                                          input logic [2:0] noise,
                                          input logic [15:0] mask,
                                          input logic [2:0] bx);
      logic [2:0] id;
      id = ideal_f(a, b);
      case (m)
         1: return {id[2], 1'b0, id[0]};
         2: return (a == 2 && b == 1) ? 3'b110 : id;
         3: return (a == 1 && b == 3) ? 3'b000 : id;
         4: return (ph < s) ? noise : id;
         5: begin
            if (ph < s) return noise;
            return mask[a*4+b] ? (id ^ bx) : id;
         end
         default: return id;
      endcase
   endfunction

   // Sweep model: n counts edges since the start edge; pair k is judged at n=(k+1)*(S+1).
   int  n_m   [2];
   bit  act_m [2];
   bit  done_m[2];
   bit  fv_m  [2];
   int  err_m [2];
   int  idx_m [2];
   int  fa_m  [2];
   int  fb_m  [2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         fl[i] = flags_f(mode_v[i], int'(a_o[i]), int'(b_o[i]),
                         act_m[i] ? (n_m[i] % (s_of(i) + 1)) : 0, s_of(i),
                         noise_v[i], mask_v[i], bx_v[i]);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         noise_v[i] <= 3'($urandom);
         bx_v[i]    <= 3'($urandom_range(1, 7));
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            n_m[i] <= 0; act_m[i] <= 0; done_m[i] <= 0; fv_m[i] <= 0;
            err_m[i] <= 0; idx_m[i] <= 0; fa_m[i] <= 0; fb_m[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int nn, k, pa, pb;
            if (!act_m[i]) begin
               if (start_v[i]) begin
                  act_m[i] <= 1; n_m[i] <= 0; done_m[i] <= 0; fv_m[i] <= 0;
                  err_m[i] <= 0; idx_m[i] <= 0; fa_m[i] <= 0; fb_m[i] <= 0;
               end
            end else begin
               nn = n_m[i] + 1;
               n_m[i] <= nn;
               if (nn % (s_of(i) + 1) == 0) begin
                  k  = nn / (s_of(i) + 1) - 1;
                  pa = k / 4;
                  pb = k % 4;
                  if (fl[i] != ideal_f(pa, pb)) begin
                     err_m[i] <= err_m[i] + 1;
                     if (!fv_m[i]) begin
                        fv_m[i] <= 1; fa_m[i] <= pa; fb_m[i] <= pb;
                     end
                  end
                  if (k == N - 1) begin
                     act_m[i]  <= 0;
                     done_m[i] <= 1;
                  end else begin
                     idx_m[i] <= k + 1;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int i, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s inst%0d @%0t: got %0d expected %0d", name, i, $time, got, exp);
      end
   endtask

   task automatic start_and_wait(input int i, input int restart_at, output int t);
      @(posedge clk); #1 start_v[i] = 1'b1;
      @(posedge clk); #1 start_v[i] = 1'b0;
      chk("start_clears_done", i, done_o[i], 0);
      chk("start_sets_busy", i, busy_o[i], 1);
      chk("start_a0", i, a_o[i], 0);
      chk("start_b0", i, b_o[i], 0);
      t = -1;
      for (int j = 1; j <= 200; j++) begin
         @(posedge clk); #1;
         if (restart_at > 0 && j == restart_at - 1) start_v[i] = 1'b1;
         if (restart_at > 0 && j == restart_at)     start_v[i] = 1'b0;
         if (done_o[i]) begin
            t = j;
            break;
         end
      end
      if (t < 0) chk("done_timeout", i, 0, 1);
   endtask

   task automatic run(input int i, input int m, input logic [15:0] mask,
                      input int restart_at, output int t);
      mode_v[i] = m;
      mask_v[i] = mask;
      start_and_wait(i, restart_at, t);
   endtask

   initial begin
      int t, low;
      logic [15:0] mask;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0; mode_v[i] = 0; mask_v[i] = '0;
      end

      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               for (int i = 0; i < 2; i++) begin
                  chk("a_out", i, a_o[i], idx_m[i] / 4);
                  chk("b_out", i, b_o[i], idx_m[i] % 4);
                  chk("busy", i, busy_o[i], act_m[i]);
                  chk("done", i, done_o[i], done_m[i]);
                  chk("pass", i, pass_o[i], (done_m[i] && err_m[i] == 0) ? 1 : 0);
                  chk("err_count", i, err_o[i], err_m[i]);
                  chk("fail_valid", i, fv_o[i], fv_m[i]);
                  chk("fail_a", i, fa_o[i], fa_m[i]);
                  chk("fail_b", i, fb_o[i], fb_m[i]);
               end
            end
         end
         begin
            #2000000;
            $display("FAIL watchdog expired at %0t", $time);
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 0, busy_o[0], 0);
      chk("rst_done", 0, done_o[0], 0);
      chk("rst_err", 0, err_o[0], 0);
      chk("rst_a", 1, a_o[1], 0);
      rst = 1'b0;

      // Ideal comparator
      run(0, 0, '0, 0, t);
      chk("ideal_done_edge", 0, t, 32);
      chk("ideal_pass", 0, pass_o[0], 1);
      chk("ideal_err", 0, err_o[0], 0);
      chk("ideal_fv", 0, fv_o[0], 0);

      // eq stuck at 0
      run(0, 1, '0, 0, t);
      chk("eq0_err", 0, err_o[0], 4);
      chk("eq0_pass", 0, pass_o[0], 0);
      chk("eq0_fv", 0, fv_o[0], 1);
      chk("eq0_fa", 0, fa_o[0], 0);
      chk("eq0_fb", 0, fb_o[0], 0);

      // Multi-hot on (2,1)
      run(0, 2, '0, 0, t);
      chk("multihot_err", 0, err_o[0], 1);
      chk("multihot_fa", 0, fa_o[0], 2);
      chk("multihot_fb", 0, fb_o[0], 1);

      // All-zero flags on (1,3)
      run(0, 3, '0, 0, t);
      chk("allzero_err", 0, err_o[0], 1);
      chk("allzero_fa", 0, fa_o[0], 1);
      chk("allzero_fb", 0, fb_o[0], 3);

      // Start while busy is ignored
      run(0, 0, '0, 10, t);
      chk("busy_start_done_edge", 0, t, 32);
      chk("busy_start_pass", 0, pass_o[0], 1);

      // Async reset while pair (1,2) is presented
      mode_v[0] = 1;
      @(posedge clk); #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("pre_rst_a", 0, a_o[0], 1);
      chk("pre_rst_b", 0, b_o[0], 2);
      chk("pre_rst_err", 0, err_o[0], 2);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_a", 0, a_o[0], 0);
      chk("rst_mid_b", 0, b_o[0], 0);
      chk("rst_mid_busy", 0, busy_o[0], 0);
      chk("rst_mid_err", 0, err_o[0], 0);
      chk("rst_mid_fv", 0, fv_o[0], 0);
      @(posedge clk); #1 rst = 1'b0;
      run(0, 0, '0, 0, t);
      chk("post_rst_done_edge", 0, t, 32);
      chk("post_rst_err", 0, err_o[0], 0);

      // Longer settle with flags garbage for all but the sampled cycle
      run(1, 4, '0, 0, t);
      chk("s3_done_edge", 1, t, 64);
      chk("s3_glitch_pass", 1, pass_o[1], 1);
      run(1, 3, '0, 0, t);
      chk("s3_allzero_err", 1, err_o[1], 1);
      chk("s3_allzero_fa", 1, fa_o[1], 1);
      chk("s3_allzero_fb", 1, fb_o[1], 3);

      // Random faulty pairs with random corruption and settle glitches
      for (int r = 0; r < 8; r++) begin
         mask = 16'($urandom);
         run(r % 2, 5, mask, 0, t);
         chk("rand_err", r % 2, err_o[r % 2], $countones(mask));
         chk("rand_pass", r % 2, pass_o[r % 2], (mask == 0) ? 1 : 0);
         if (mask != 0) begin
            low = 0;
            while (!mask[low]) low++;
            chk("rand_fa", r % 2, fa_o[r % 2], low / 4);
            chk("rand_fb", r % 2, fb_o[r % 2], low % 4);
         end
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
